// File: rtl/aes_pkg.sv
// Shared AES definitions: round constants, control encodings and the
// column/row transforms used by the encipher and decipher datapaths.
package aes_pkg;

   localparam logic [3:0] AES128_ROUNDS   = 4'ha;
   localparam logic [3:0] AES256_ROUNDS   = 4'he;
   localparam logic       AES_128_BIT_KEY = 1'b0;

   typedef enum logic [1:0] {
      CTRL_IDLE = 2'd0,
      CTRL_INIT = 2'd1,
      CTRL_SBOX = 2'd2,
      CTRL_MAIN = 2'd3
   } ctrl_state_t;

   typedef enum logic [2:0] {
      NO_UPDATE    = 3'd0,
      INIT_UPDATE  = 3'd1,
      SBOX_UPDATE  = 3'd2,
      MAIN_UPDATE  = 3'd3,
      FINAL_UPDATE = 3'd4
   } update_type_t;

   // Number of rounds for the given key length selector.
   function automatic logic [3:0] num_rounds(input logic keylen);
      return (keylen == AES_128_BIT_KEY) ? AES128_ROUNDS : AES256_ROUNDS;
   endfunction

   // Multiply by 2 in GF(2^8), reduction polynomial 0x11b.
   function automatic logic [7:0] gm2(input logic [7:0] op);
      return {op[6:0], 1'b0} ^ (8'h1b & {8{op[7]}});
   endfunction

   // Multiply by 3 in GF(2^8).
   function automatic logic [7:0] gm3(input logic [7:0] op);
      return gm2(op) ^ op;
   endfunction

   // MixColumns on one 32-bit column; byte 0 is bits 31:24.
   function automatic logic [31:0] mixw(input logic [31:0] w);
      logic [7:0] b0, b1, b2, b3;
      logic [7:0] mb0, mb1, mb2, mb3;
      b0  = w[31:24];
      b1  = w[23:16];
      b2  = w[15:8];
      b3  = w[7:0];
      mb0 = gm2(b0) ^ gm3(b1) ^ b2      ^ b3;
      mb1 = b0      ^ gm2(b1) ^ gm3(b2) ^ b3;
      mb2 = b0      ^ b1      ^ gm2(b2) ^ gm3(b3);
      mb3 = gm3(b0) ^ b1      ^ b2      ^ gm2(b3);
      return {mb0, mb1, mb2, mb3};
   endfunction

   function automatic logic [127:0] mixcolumns(input logic [127:0] data);
      return {mixw(data[127:96]), mixw(data[95:64]),
              mixw(data[63:32]),  mixw(data[31:0])};
   endfunction

   // Row r of column c comes from column (c + r) mod 4.
   function automatic logic [127:0] shiftrows(input logic [127:0] data);
      logic [31:0] w0, w1, w2, w3;
      logic [31:0] ws0, ws1, ws2, ws3;
      w0  = data[127:96];
      w1  = data[95:64];
      w2  = data[63:32];
      w3  = data[31:0];
      ws0 = {w0[31:24], w1[23:16], w2[15:8], w3[7:0]};
      ws1 = {w1[31:24], w2[23:16], w3[15:8], w0[7:0]};
      ws2 = {w2[31:24], w3[23:16], w0[15:8], w1[7:0]};
      ws3 = {w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
      return {ws0, ws1, ws2, ws3};
   endfunction

   function automatic logic [127:0] addroundkey(input logic [127:0] data,
                                                input logic [127:0] rkey);
      return data ^ rkey;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box applied to all four bytes of a 32-bit word in parallel.
module aes_sbox (
   input  logic [31:0] sboxw,
   output logic [31:0] new_sboxw
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign new_sboxw[gi*8 +: 8] = SBOX[sboxw[gi*8 +: 8]];
      end
   endgenerate

endmodule

// File: rtl/aes_encipher_block.sv
// Word-serial AES-128/256 encipher round engine. One S-box is shared over
// the four state words; round keys are fetched by index each cycle.
module aes_encipher_block
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         next,
   input  logic         keylen,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   input  logic [127:0] block,
   output logic [127:0] new_block,
   output logic         ready
);

   ctrl_state_t  ctrl_reg;
   ctrl_state_t  ctrl_next;
   update_type_t update_type;

   logic [3:0]   round_ctr_reg;
   logic [1:0]   sword_ctr_reg;
   logic         ready_reg;
   logic         keylen_reg;

   logic         round_ctr_rst;
   logic         round_ctr_inc;
   logic         sword_ctr_rst;
   logic         sword_ctr_inc;
   logic         ready_set;
   logic         ready_clr;
   logic         keylen_we;

   logic [31:0]  w_reg [4];
   logic [3:0]   w_we;
   logic [127:0] state;
   logic [127:0] state_next;
   logic [31:0]  sbox_in;
   logic [31:0]  sbox_out;
   logic         last_round;

   assign state      = {w_reg[0], w_reg[1], w_reg[2], w_reg[3]};
   assign last_round = (round_ctr_reg >= num_rounds(keylen_reg));
   assign sbox_in    = w_reg[sword_ctr_reg];

   assign round      = round_ctr_reg;
   assign new_block  = state;
   assign ready      = ready_reg;

   aes_sbox u_sbox (
      .sboxw     (sbox_in),
      .new_sboxw (sbox_out)
   );

   // Control state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_reg <= CTRL_IDLE;
      end else begin
         ctrl_reg <= ctrl_next;
      end
   end

   // Next-state decode.
   always_comb begin
      ctrl_next = ctrl_reg;
      case (ctrl_reg)
         CTRL_IDLE: if (next) ctrl_next = CTRL_INIT;
         CTRL_INIT: ctrl_next = CTRL_SBOX;
         CTRL_SBOX: if (sword_ctr_reg == 2'd3) ctrl_next = CTRL_MAIN;
         CTRL_MAIN: ctrl_next = last_round ? CTRL_IDLE : CTRL_SBOX;
         default:   ctrl_next = CTRL_IDLE;
      endcase
   end

   // Per-state control strobes and datapath update selection.
   always_comb begin
      round_ctr_rst = 1'b0;
      round_ctr_inc = 1'b0;
      sword_ctr_rst = 1'b0;
      sword_ctr_inc = 1'b0;
      ready_set     = 1'b0;
      ready_clr     = 1'b0;
      keylen_we     = 1'b0;
      update_type   = NO_UPDATE;
      case (ctrl_reg)
         CTRL_IDLE: begin
            if (next) begin
               round_ctr_rst = 1'b1;
               ready_clr     = 1'b1;
               keylen_we     = 1'b1;
            end
         end
         CTRL_INIT: begin
            round_ctr_inc = 1'b1;
            sword_ctr_rst = 1'b1;
            update_type   = INIT_UPDATE;
         end
         CTRL_SBOX: begin
            sword_ctr_inc = 1'b1;
            update_type   = SBOX_UPDATE;
         end
         CTRL_MAIN: begin
            sword_ctr_rst = 1'b1;
            if (!last_round) begin
               // Round counter is left at Nr after the final round.
               round_ctr_inc = 1'b1;
               update_type   = MAIN_UPDATE;
            end else begin
               ready_set     = 1'b1;
               update_type   = FINAL_UPDATE;
            end
         end
         default: ;
      endcase
   end

   // New state value and per-word write enables for the selected update.
   always_comb begin
      state_next = '0;
      w_we       = 4'b0000;
      case (update_type)
         INIT_UPDATE: begin
            state_next = addroundkey(block, round_key);
            w_we       = 4'b1111;
         end
         SBOX_UPDATE: begin
            // Every word sees the S-box output; only the addressed one is written.
            state_next           = {4{sbox_out}};
            w_we[sword_ctr_reg]  = 1'b1;
         end
         MAIN_UPDATE: begin
            state_next = addroundkey(mixcolumns(shiftrows(state)), round_key);
            w_we       = 4'b1111;
         end
         FINAL_UPDATE: begin
            state_next = addroundkey(shiftrows(state), round_key);
            w_we       = 4'b1111;
         end
         default: ;
      endcase
   end

   // Four independently enabled state word registers; w0 is the MSW.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_word
         logic [31:0] word_reg;
         // Word register with its own write enable.
         always_ff @(posedge clk) begin
            if (reset) begin
               word_reg <= '0;
            end else if (w_we[gi]) begin
               word_reg <= state_next[127 - 32*gi -: 32];
            end
         end
         assign w_reg[gi] = word_reg;
      end
   endgenerate

   // Round/word counters, ready flag and key length latch.
   always_ff @(posedge clk) begin
      if (reset) begin
         round_ctr_reg <= '0;
         sword_ctr_reg <= '0;
         ready_reg     <= 1'b1;
         keylen_reg    <= 1'b0;
      end else begin
         if (round_ctr_rst) begin
            round_ctr_reg <= '0;
         end else if (round_ctr_inc) begin
            round_ctr_reg <= round_ctr_reg + 4'd1;
         end
         if (sword_ctr_rst) begin
            sword_ctr_reg <= '0;
         end else if (sword_ctr_inc) begin
            sword_ctr_reg <= sword_ctr_reg + 2'd1;
         end
         if (ready_clr) begin
            ready_reg <= 1'b0;
         end else if (ready_set) begin
            ready_reg <= 1'b1;
         end
         if (keylen_we) begin
            keylen_reg <= keylen;
         end
      end
   end

endmodule
